// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and readout bundle for the BCD stopwatch controller.
// The command source drives master; the controller is slave.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   disp;
    logic                  running;
    logic                  overflow;
    logic [1:0]            state;

    modport master (
        output start, stop, clear, lap,
        input  count, disp, running, overflow, state
    );

    modport slave (
        input  start, stop, clear, lap,
        output count, disp, running, overflow, state
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/lap sequencer for a cascaded BCD counter chain, with a prescaler,
// a freezable display copy and a sticky wrap flag.
//
//   state | meaning
//   IDLE  | zeroed, not counting
//   RUN   | counting, display follows live count
//   PAUSE | counting held, prescaler phase held
//   LAP   | counting, display frozen at lap value
module bcd_stopwatch_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    bcd_stopwatch_ctrl_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TC_LOAD = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t                state_r, state_nxt;
    logic [4*DIGITS-1:0]   count_r, count_inc, lap_r;
    logic [PW-1:0]         pre_r;
    logic                  overflow_r;
    logic                  active, step, wrap, carry;
    logic                  load_pre, cap_lap;

    // Prescaler counts down; reaching zero is the terminal count that steps.
    assign active = (state_r == RUN) || (state_r == LAP);
    assign step   = active && (pre_r == '0);

    always_comb begin
        count_inc = count_r;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                count_inc[4*i +: 4] = (count_r[4*i +: 4] == 4'd9) ? 4'd0
                                                                 : count_r[4*i +: 4] + 4'd1;
            end
            carry = carry && (count_r[4*i +: 4] == 4'd9);
        end
        wrap = carry;
    end

    // Strict priority: only the highest asserted command is considered, even
    // when the current state ignores it.
    always_comb begin
        state_nxt = state_r;
        load_pre  = 1'b0;
        cap_lap   = 1'b0;
        if (!bus.clear) begin
            case (state_r)
                IDLE: begin
                    if (!bus.stop && bus.start) begin
                        state_nxt = RUN;
                        load_pre  = 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state_nxt = PAUSE;
                    end else if (!bus.start && bus.lap) begin
                        state_nxt = LAP;
                        cap_lap   = 1'b1;
                    end
                end
                PAUSE: begin
                    if (!bus.stop && bus.start) begin
                        state_nxt = RUN;
                    end
                end
                LAP: begin
                    if (bus.stop) begin
                        state_nxt = PAUSE;
                    end else if (!bus.start && bus.lap) begin
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset || bus.clear) begin
            state_r    <= IDLE;
            count_r    <= '0;
            lap_r      <= '0;
            pre_r      <= PRE_TC_LOAD;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            if (load_pre) begin
                pre_r <= PRE_TC_LOAD;
            end else if (active) begin
                pre_r <= (pre_r == '0) ? PRE_TC_LOAD : pre_r - 1'b1;
            end
            if (step) begin
                count_r <= count_inc;
                if (wrap) begin
                    overflow_r <= 1'b1;
                end
            end
            if (cap_lap) begin
                lap_r <= step ? count_inc : count_r;
            end
        end
    end

    assign bus.count    = count_r;
    assign bus.disp     = (state_r == LAP) ? lap_r : count_r;
    assign bus.running  = active;
    assign bus.overflow = overflow_r;
    assign bus.state    = state_r;
endmodule
